// File: rtl/full_as_reg_if.sv
// -----------------------------------------------------------------------------
// full_as_reg_if
//
// Purpose:
//   Bundles the operand/valid inputs and the registered result outputs of
//   full_as_reg into one interface. Clock and reset stay outside as plain
//   ports of the design.
//
// Parameters:
//   WIDTH      operand width in bits. It must match the WIDTH of the
//              full_as_reg instance that this interface is connected to.
//
// Signals:
//   in_valid   a/b/c are presented this cycle (master -> slave).
//   a, b       unsigned operands, WIDTH bits (master -> slave).
//   c          shared carry-in / borrow-in (master -> slave).
//   out_valid  the result registers hold a freshly captured result.
//   sum        low WIDTH bits of a+b+c.
//   carry      bit WIDTH of a+b+c.
//   diff       low WIDTH bits of a-b-c, modulo 2^WIDTH.
//   barrow     borrow-out, set when a < b+c.
//
// Modports:
//   master     the operand source (a testbench or an upstream block).
//   slave      the full_as_reg datapath.
// -----------------------------------------------------------------------------
interface full_as_reg_if #(
    parameter int WIDTH = 1
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;

    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] diff;
    logic             barrow;

    modport master (
        output in_valid,
        output a,
        output b,
        output c,
        input  out_valid,
        input  sum,
        input  carry,
        input  diff,
        input  barrow
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  c,
        output out_valid,
        output sum,
        output carry,
        output diff,
        output barrow
    );

endinterface

// File: rtl/full_as_reg.sv
// -----------------------------------------------------------------------------
// full_as_reg
//
// Purpose:
//   Registered combined full adder / full subtractor. From the same operands
//   a, b and the shared carry/borrow-in c, it computes both a+b+c (sum,
//   carry) and a-b-c (diff, barrow) in one cycle. All four results are
//   captured in output registers together with a valid flag. WIDTH=1 gives
//   the classic 1-bit full adder-subtractor leaf cell.
//
// Parameters:
//   WIDTH      operand width in bits, 1..32.
//
// Ports:
//   clk        rising-edge clock.
//   rst        asynchronous, active-high reset. It clears every output
//              register.
//   bus        full_as_reg_if.slave:
//                in_valid, a, b, c        -> operands, captured when
//                                            in_valid=1.
//                out_valid, sum, carry,   <- registered results, one cycle
//                diff, barrow                after the qualifying input.
//
// Timing:
//   The latency is one clock and the throughput is one result per cycle.
//   There is no backpressure. When in_valid=0 the data registers hold their
//   value and only out_valid drops. Inputs are ignored in that cycle, even
//   if they are X/Z.
// -----------------------------------------------------------------------------
module full_as_reg #(
    parameter int WIDTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    full_as_reg_if.slave  bus
);

    // -------------------------------------------------------------------------
    // Combinational core: two ripple chains seeded by the same c.
    //   k[i] : carry into bit i of the adder    (k[0] = c)
    //   w[i] : borrow into bit i of the subtractor (w[0] = c)
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   k;
    logic [WIDTH:0]   w;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] d_next;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        k      = '0;
        w      = '0;
        s_next = '0;
        d_next = '0;

        k[0] = bus.c;
        w[0] = bus.c;

        for (int i = 0; i < WIDTH; i++) begin
            // Adder bit: propagate when a^b, generate when a&b.
            s_next[i] = bus.a[i] ^ bus.b[i] ^ k[i];
            k[i+1]    = (bus.a[i] & bus.b[i]) | (k[i] & (bus.a[i] ^ bus.b[i]));

            // Subtractor bit: a borrow is generated when a=0,b=1. An incoming
            // borrow passes on when a==b.
            d_next[i] = bus.a[i] ^ bus.b[i] ^ w[i];
            w[i+1]    = (~bus.a[i] & bus.b[i]) | (w[i] & ~(bus.a[i] ^ bus.b[i]));
        end
    end

    // -------------------------------------------------------------------------
    // Output registers.
    // The data registers load only on in_valid, so X/Z on idle inputs never
    // reach them. out_valid follows in_valid one cycle late.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.carry     <= 1'b0;
            bus.diff      <= '0;
            bus.barrow    <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum    <= s_next;
                bus.carry  <= k[WIDTH];
                bus.diff   <= d_next;
                bus.barrow <= w[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_as_reg.sv
// -----------------------------------------------------------------------------
// tb_full_as_reg
//
// Self-checking bench for full_as_reg at WIDTH=1, 4 and 8. The three
// instances share clk/rst. Expected values come from an arithmetic
// reference (a+b+c, a-b-c, a < b+c) or from hand-derived constants.
// -----------------------------------------------------------------------------
module tb_full_as_reg;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    full_as_reg_if #(.WIDTH(1)) if1 ();
    full_as_reg_if #(.WIDTH(4)) if4 ();
    full_as_reg_if #(.WIDTH(8)) if8 ();

    full_as_reg #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    full_as_reg #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    full_as_reg #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic [31:0] diff;
        logic        barrow;
    } res_t;

    int errors = 0;
    int checks = 0;

    // Reference: plain unsigned arithmetic, reduced modulo 2^w.
    function automatic res_t model(input int w, input longint unsigned a,
                                   input longint unsigned b, input longint unsigned c);
        res_t            r;
        longint unsigned mask;
        longint unsigned total;
        longint unsigned delta;
        mask     = (64'd1 << w) - 64'd1;
        total    = a + b + c;
        delta    = a - b - c;
        r.sum    = 32'(total & mask);
        r.carry  = total[w];
        r.diff   = 32'(delta & mask);
        r.barrow = (a < (b + c));
        return r;
    endfunction

    function automatic res_t mk(input logic [31:0] s, input logic k,
                                input logic [31:0] d, input logic bw);
        res_t r;
        r.sum = s; r.carry = k; r.diff = d; r.barrow = bw;
        return r;
    endfunction

    function automatic res_t obs1();
        return mk(32'(if1.sum), if1.carry, 32'(if1.diff), if1.barrow);
    endfunction
    function automatic res_t obs4();
        return mk(32'(if4.sum), if4.carry, 32'(if4.diff), if4.barrow);
    endfunction
    function automatic res_t obs8();
        return mk(32'(if8.sum), if8.carry, 32'(if8.diff), if8.barrow);
    endfunction

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_res(input string tag, input logic ov, input res_t o,
                           input logic exp_ov, input res_t e);
        chk({tag, ".out_valid"}, 32'(ov), 32'(exp_ov));
        chk({tag, ".sum"},       o.sum,   e.sum);
        chk({tag, ".carry"},     32'(o.carry),  32'(e.carry));
        chk({tag, ".diff"},      o.diff,  e.diff);
        chk({tag, ".barrow"},    32'(o.barrow), 32'(e.barrow));
    endtask

    task automatic drive1(input logic a, input logic b, input logic c, input logic v);
        if1.a = a; if1.b = b; if1.c = c; if1.in_valid = v;
    endtask
    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic v);
        if4.a = a; if4.b = b; if4.c = c; if4.in_valid = v;
    endtask
    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
        if8.a = a; if8.b = b; if8.c = c; if8.in_valid = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    res_t zero;
    res_t held;

    // Directed WIDTH=4 vectors with hand-derived results.
    logic [3:0] d4_a     [5] = '{4'd15, 4'd9,  4'd3,  4'd12, 4'd0};
    logic [3:0] d4_b     [5] = '{4'd15, 4'd6,  4'd5,  4'd4,  4'd15};
    logic       d4_c     [5] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
    logic [3:0] d4_sum   [5] = '{4'd15, 4'd15, 4'd9,  4'd1,  4'd0};
    logic       d4_carry [5] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    logic [3:0] d4_diff  [5] = '{4'd15, 4'd3,  4'd13, 4'd7,  4'd0};
    logic       d4_bw    [5] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};

    initial begin
        zero = '0;
        rst  = 1'b1;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive4(4'd0, 4'd0, 1'b0, 1'b0);
        drive8(8'd0, 8'd0, 1'b0, 1'b0);

        // Reset state.
        repeat (2) tick();
        chk_res("reset1", if1.out_valid, obs1(), 1'b0, zero);
        chk_res("reset4", if4.out_valid, obs4(), 1'b0, zero);
        rst = 1'b0;

        // Capture a nonzero result, then assert reset between edges.
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        drive4(4'd1, 4'd1, 1'b1, 1'b1);
        tick();
        chk_res("pre_rst1", if1.out_valid, obs1(), 1'b1, model(1, 1, 1, 1));
        #2;
        rst = 1'b1;
        #1;
        chk_res("async_rst1", if1.out_valid, obs1(), 1'b0, zero);
        chk_res("async_rst4", if4.out_valid, obs4(), 1'b0, zero);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_res("rst_hold1", if1.out_valid, obs1(), 1'b0, zero);
        end
        rst = 1'b0;
        tick();
        chk_res("rst_release1", if1.out_valid, obs1(), 1'b1, model(1, 1, 1, 1));
        drive4(4'd0, 4'd0, 1'b0, 1'b0);

        // WIDTH=1 exhaustive truth table, back to back.
        for (int r = 0; r < 8; r++) begin
            logic [2:0] rv;
            rv = 3'(r);
            drive1(rv[2], rv[1], rv[0], 1'b1);
            tick();
            chk_res($sformatf("w1_row%0d", r), if1.out_valid, obs1(), 1'b1,
                    model(1, rv[2], rv[1], rv[0]));
        end

        // Hold: capture 1,0,1, then toggle the inputs (including X) with in_valid=0.
        drive1(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        held = mk(32'd0, 1'b1, 32'd0, 1'b0);
        chk_res("hold_cap", if1.out_valid, obs1(), 1'b1, held);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                if1.in_valid = 1'b0; if1.a = 1'bx; if1.b = 1'bz; if1.c = 1'bx;
            end else begin
                drive1(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end
            tick();
            chk_res($sformatf("hold%0d", i), if1.out_valid, obs1(), 1'b0, held);
        end

        // WIDTH=4 directed boundary vectors.
        for (int i = 0; i < 5; i++) begin
            drive4(d4_a[i], d4_b[i], d4_c[i], 1'b1);
            tick();
            chk_res($sformatf("w4_vec%0d", i), if4.out_valid, obs4(), 1'b1,
                    mk(32'(d4_sum[i]), d4_carry[i], 32'(d4_diff[i]), d4_bw[i]));
        end
        drive4(4'd7, 4'd2, 1'b0, 1'b0);
        tick();
        chk_res("w4_idle", if4.out_valid, obs4(), 1'b0,
                mk(32'(d4_sum[4]), d4_carry[4], 32'(d4_diff[4]), d4_bw[4]));

        // WIDTH=8: 16 random vectors back to back, with no bubbles.
        begin
            logic [7:0] ra, rb;
            logic       rc;
            for (int i = 0; i < 16; i++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rc = 1'($urandom);
                drive8(ra, rb, rc, 1'b1);
                tick();
                held = model(8, ra, rb, rc);
                chk_res($sformatf("w8_rand%0d", i), if8.out_valid, obs8(), 1'b1, held);
            end
            drive8(8'd0, 8'd255, 1'b1, 1'b0);
            tick();
            chk_res("w8_idle", if8.out_valid, obs8(), 1'b0, held);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/full_as_reg.md
Name: full_as_reg

Overview:
- Registered combined full adder / full subtractor.
- Inputs a, b and a shared carry/borrow-in c produce sum/carry (a+b+c) and diff/borrow (a-b-c) in the same cycle. All four results are captured in output registers.
- Datapath width is parameterised. WIDTH=1 gives the classic 1-bit full adder-subtractor used as the arithmetic leaf cell in lab datapaths.
- A simple valid flag travels alongside the data.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a/b/c are presented this cycle; capture a new result.
- a  input  WIDTH  minuend / first addend (unsigned).
- b  input  WIDTH  subtrahend / second addend (unsigned).
- c  input  1  shared carry-in (add path) and borrow-in (subtract path).
- out_valid  output  1  sum/carry/diff/barrow hold a result captured from a valid input.
- sum  output  WIDTH  low WIDTH bits of a+b+c.
- carry  output  1  carry-out, bit WIDTH of a+b+c.
- diff  output  WIDTH  low WIDTH bits of a-b-c, modulo 2^WIDTH.
- barrow  output  1  borrow-out; 1 iff a < b+c (unsigned).

Behaviour:
- Reset:
  - rst=1 asynchronously forces sum=0, carry=0, diff=0, barrow=0, out_valid=0, independent of clk.
  - Outputs stay at these values while rst is high.
  - Release is synchronous in effect: the first capture happens on the first rising clk edge with rst=0.
  - Reset asserted mid-operation discards any pending result immediately.
- Combinational core, per bit i, ripple from bit 0 with carry/borrow chain seeded by c:
  - Add: s_i = a_i^b_i^k_i; k_(i+1) = a_i&b_i | k_i&(a_i^b_i).
  - Sub: d_i = a_i^b_i^w_i; w_(i+1) = ~a_i&b_i | w_i&~(a_i^b_i).
  - carry = k_WIDTH; barrow = w_WIDTH.
- Add and subtract are computed concurrently from the same inputs; there is no mode select. Both result sets are always produced.
- Capture on rising clk:
  - If in_valid=1: register all four results and set out_valid=1.
  - If in_valid=0: hold previous sum/carry/diff/barrow and clear out_valid to 0.
- Latency: exactly 1 clock from in_valid-qualified inputs to outputs. Throughput: one result per cycle. No backpressure.
- Boundary conditions:
  - Unsigned wrap-around only; no overflow flag.
  - a=b=all-ones, c=1 gives sum=all-ones, carry=1.
  - a=0, b=all-ones, c=1 gives diff=0, barrow=1.
  - a=b, c=0 gives diff=0, barrow=0.
- X/Z on inputs while in_valid=0 must not disturb registered outputs.
- With WIDTH=1 the truth table (a,b,c -> sum,carry,diff,barrow) is:
  - 000->0,0,0,0
  - 001->1,0,1,1
  - 010->1,0,1,1
  - 011->0,1,0,1
  - 100->1,0,1,0
  - 101->0,1,0,0
  - 110->0,1,0,0
  - 111->1,1,1,1

Test Plan:
- Reset: drive inputs a=1,b=1,c=1,in_valid=1 and assert rst between clock edges -> all outputs 0 and out_valid=0 immediately, without waiting for a clock edge; outputs stay 0 through 3 edges while rst=1.
- WIDTH=1 exhaustive: apply all 8 (a,b,c) combinations, one per cycle with in_valid=1 -> each row of the truth table appears one cycle later with out_valid=1.
- Hold: after a=1,b=0,c=1 is captured (sum=0,carry=1,diff=0,barrow=0), drop in_valid and toggle a/b/c for 4 cycles -> data outputs unchanged, out_valid=0.
- WIDTH=4 add wrap: a=15,b=15,c=1 -> sum=15, carry=1; a=9,b=6,c=0 -> sum=15, carry=0.
- WIDTH=4 subtract borrow: a=3,b=5,c=1 -> diff=13, barrow=1; a=12,b=4,c=1 -> diff=7, barrow=0; a=0,b=15,c=1 -> diff=0, barrow=1.
- Back-to-back: 16 random vectors, one per cycle with in_valid=1 (WIDTH=8) -> each output matches the a+b+c and a-b-c reference exactly one cycle later; no bubbles.
